// File: rtl/pipe_ctrl_pkg.sv
// Shared core package for the pipeline controller.
// Holds the PC width, the controller FSM state encodings and the next-PC
// select constants used by the fetch stage.
package pipe_ctrl_pkg;

  localparam int XLEN = 32;

  // Controller FSM states.
  typedef enum logic {
    PC_RUN        = 1'b0,
    PC_REDIR_WAIT = 1'b1
  } pc_state_e;

  // Next-PC source selects used by the fetch stage.
  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JALR = 2'd2;
  localparam logic [1:0] NPC_EXC  = 2'd3;

endpackage

// File: rtl/pipe_ctrl_lu_detect.sv
// Load-use hazard detector.
// Flags when the ID instruction reads a register that the EX-stage load
// has not yet produced. x0 never creates a hazard.
module lu_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic [4:0] ex_rd,
  input  logic       ex_we,
  input  logic       ex_is_load,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  // Compare each used source operand against the load destination.
  always_comb begin
    rs1_hit = id_re1 && (id_rs1 == ex_rd);
    rs2_hit = id_re2 && (id_rs2 == ex_rd);
    lu      = ex_is_load && ex_we && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// Generates PC/IF/ID stall, flush and redirect controls from the EX-stage
// redirect, the load-use hazard and the fetch handshake.
// Optional build macro: PIPE_CTRL_PERF_EN adds four 32-bit performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = pipe_ctrl_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bpu_flush,
  input  logic [XLEN-1:0] bpu_flush_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_re1,
  input  logic            id_re2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic            if_ready,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_flushes,
  output logic [31:0]     perf_lu_stalls,
  output logic [31:0]     perf_fetch_wait
`endif
);

  pc_state_e       state;
  logic [XLEN-1:0] pend_pc;
  logic            lu;

  lu_detect u_lu_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_re1     (id_re1),
    .id_re2     (id_re2),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_is_load (ex_is_load),
    .lu         (lu)
  );

  // Combinational control outputs; everything is held at 0 while in reset.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves a latch.
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst_n) begin
      unique case (state)
        PC_RUN: begin
          if (bpu_flush) begin
            // Wrong-path instructions in IF and ID; a load-use on them is moot.
            redirect_valid = 1'b1;
            redirect_pc    = bpu_flush_pc;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
          end else if (lu) begin
            // One bubble: hold PC and IF/ID, inject a bubble into ID/EX.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (!if_ready) begin
            // Fetch miss: hold PC, bubble into IF/ID, let ID/EX drain.
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        PC_REDIR_WAIT: begin
          // A newer redirect overrides the pending one in the same cycle.
          redirect_valid = 1'b1;
          redirect_pc    = bpu_flush ? bpu_flush_pc : pend_pc;
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM and pending redirect target.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= PC_RUN;
      pend_pc <= '0;
    end else begin
      unique case (state)
        PC_RUN: begin
          if (bpu_flush && !if_ready) begin
            pend_pc <= bpu_flush_pc;
            state   <= PC_REDIR_WAIT;
          end
        end
        PC_REDIR_WAIT: begin
          if (bpu_flush) pend_pc <= bpu_flush_pc;
          if (if_ready)  state   <= PC_RUN;
        end
        default: state <= PC_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cnt_cycles;
  logic [31:0] cnt_flushes;
  logic [31:0] cnt_lu_stalls;
  logic [31:0] cnt_fetch_wait;

  // Free-running wrapping event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_cycles     <= '0;
      cnt_flushes    <= '0;
      cnt_lu_stalls  <= '0;
      cnt_fetch_wait <= '0;
    end else begin
      cnt_cycles <= cnt_cycles + 32'd1;
      if ((state == PC_RUN) && bpu_flush)        cnt_flushes    <= cnt_flushes + 32'd1;
      if ((state == PC_RUN) && !bpu_flush && lu) cnt_lu_stalls  <= cnt_lu_stalls + 32'd1;
      if (!if_ready)                             cnt_fetch_wait <= cnt_fetch_wait + 32'd1;
    end
  end

  // Counter ports read 0 while reset is held.
  always_comb begin
    perf_cycles     = rst_n ? cnt_cycles     : 32'd0;
    perf_flushes    = rst_n ? cnt_flushes    : 32'd0;
    perf_lu_stalls  = rst_n ? cnt_lu_stalls  : 32'd0;
    perf_fetch_wait = rst_n ? cnt_fetch_wait : 32'd0;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic compared against a behavioural model of the control rules.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] fpc;
  logic [4:0]  rs1, rs2, rd;
  logic        re1, re2, we, ld, rdy;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_flushes, perf_lu_stalls, perf_fetch_wait;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: whether a redirect is outstanding, and its target.
  bit          m_pending = 1'b0;
  logic [31:0] m_target  = 32'd0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bpu_flush      (flush),
    .bpu_flush_pc   (fpc),
    .id_rs1         (rs1),
    .id_rs2         (rs2),
    .id_re1         (re1),
    .id_re2         (re2),
    .ex_rd          (rd),
    .ex_we          (we),
    .ex_is_load     (ld),
    .if_ready       (rdy),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_cycles     (perf_cycles),
    .perf_flushes    (perf_flushes),
    .perf_lu_stalls  (perf_lu_stalls),
    .perf_fetch_wait (perf_fetch_wait)
`endif
  );

  // Output vector: {pc_stall, ifid_stall, ifid_flush, idex_flush, redirect_valid, redirect_pc}
  function automatic logic [36:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, idex_flush, redirect_valid, redirect_pc};
  endfunction

  function automatic bit model_lu();
    if (!(ld && we) || rd == 5'd0) return 1'b0;
    return (re1 && rs1 == rd) || (re2 && rs2 == rd);
  endfunction

  function automatic logic [36:0] model_out();
    if (!rst_n)     return 37'd0;
    if (m_pending)  return {5'b00111, flush ? fpc : m_target};
    if (flush)      return {5'b00111, fpc};
    if (model_lu()) return {5'b11010, 32'd0};
    if (!rdy)       return {5'b10100, 32'd0};
    return 37'd0;
  endfunction

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic f, input logic [31:0] p,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic e1, input logic e2,
                        input logic [4:0] d, input logic w, input logic l,
                        input logic r);
    flush = f; fpc = p; rs1 = r1; rs2 = r2; re1 = e1; re2 = e2;
    rd = d; we = w; ld = l; rdy = r;
    #2;
  endtask

  task automatic idle(input logic r);
    set_in(1'b0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, r);
  endtask

  // Advance one clock edge, moving the model forward with the pre-edge inputs.
  task automatic tick();
    bit          nxt_pending = m_pending;
    logic [31:0] nxt_target  = m_target;
    if (!rst_n) begin
      nxt_pending = 1'b0;
      nxt_target  = 32'd0;
    end else if (m_pending) begin
      if (flush) nxt_target = fpc;
      if (rdy)   nxt_pending = 1'b0;
    end else if (flush && !rdy) begin
      nxt_pending = 1'b1;
      nxt_target  = fpc;
    end
    @(posedge clk);
    m_pending = nxt_pending;
    m_target  = nxt_target;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b1);
    @(posedge clk); #1;

    // Reset: outputs forced to 0 even with an active flush / fetch miss.
    set_in(1'b1, 32'h55, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
    check("reset_forced", outs(), 37'd0);
    tick();
    check("reset_forced2", outs(), 37'd0);
    tick();
    rst_n = 1'b1;
    idle(1'b1);
    check("idle_after_reset", outs(), 37'd0);

    // Taken branch with fetch ready.
    set_in(1'b1, 32'h40, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("branch", outs(), {5'b00111, 32'h40});
    tick();
    idle(1'b1);
    check("branch_next", outs(), 37'd0);

    // Redirect with slow fetch: 3 cycles if_ready=0, then ready.
    set_in(1'b1, 32'h100, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("slow_redir_c1", outs(), {5'b00111, 32'h100});
    tick();
    idle(1'b0);
    check("slow_redir_c2", outs(), {5'b00111, 32'h100});
    tick();
    idle(1'b0);
    check("slow_redir_c3", outs(), {5'b00111, 32'h100});
    tick();
    idle(1'b1);
    check("slow_redir_c4", outs(), {5'b00111, 32'h100});
    tick();
    idle(1'b1);
    check("slow_redir_run", outs(), 37'd0);

    // Load-use on rs2, then clears once the load moves on.
    set_in(1'b0, 32'd0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    check("lu_rs2", outs(), {5'b11010, 32'd0});
    tick();
    idle(1'b1);
    check("lu_cleared", outs(), 37'd0);
    set_in(1'b0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
    check("lu_x0", outs(), 37'd0);
    set_in(1'b0, 32'd0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
    check("lu_not_read", outs(), 37'd0);
    set_in(1'b0, 32'd0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    check("lu_over_fetch_miss", outs(), {5'b11010, 32'd0});
    set_in(1'b0, 32'd0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
    check("lu_no_we", outs(), 37'd0);
    tick();

    // Fetch miss alone.
    idle(1'b0);
    check("fetch_miss", outs(), {5'b10100, 32'd0});
    tick();

    // Flush beats load-use.
    set_in(1'b1, 32'h80, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    check("flush_vs_lu", outs(), {5'b00111, 32'h80});
    tick();

    // Newer redirect while one is pending.
    set_in(1'b1, 32'h300, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h340, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("redir_override", outs(), {5'b00111, 32'h340});
    tick();
    idle(1'b0);
    check("redir_override_held", outs(), {5'b00111, 32'h340});
    tick();
    idle(1'b1);
    check("redir_override_end", outs(), {5'b00111, 32'h340});
    tick();

    // Reset mid-redirect drops the pending target.
    set_in(1'b1, 32'h200, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    check("redir_pending_200", outs(), {5'b00111, 32'h200});
    rst_n = 1'b0;
    #1;
    check("reset_mid_redir", outs(), 37'd0);
    tick();
    rst_n = 1'b1;
    idle(1'b1);
    check("after_reset_no_redir", outs(), 37'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      set_in(($urandom_range(0, 5) == 0), $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0));
      check($sformatf("rand_%0d", i), outs(), model_out());
      check($sformatf("rand_excl_%0d", i), {36'd0, ifid_stall & ifid_flush}, 37'd0);
      tick();
    end

`ifdef PIPE_CTRL_PERF_EN
    // Counters: 10 cycles with 2 flushes and 1 load-use, fetch always ready.
    rst_n = 1'b0;
    idle(1'b1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 6)
        set_in(1'b1, 32'h40, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      else if (c == 4)
        set_in(1'b0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
      else
        idle(1'b1);
      tick();
    end
    idle(1'b1);
    check("perf_cycles",     {5'd0, perf_cycles},     {5'd0, 32'd10});
    check("perf_flushes",    {5'd0, perf_flushes},    {5'd0, 32'd2});
    check("perf_lu_stalls",  {5'd0, perf_lu_stalls},  {5'd0, 32'd1});
    check("perf_fetch_wait", {5'd0, perf_fetch_wait}, {5'd0, 32'd0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the RV32 five-stage core. Takes the EX-stage redirect from the branch predictor (static not-taken; `flush`/`flush_pc`), ID/EX load-use operand information and the instruction-fetch completion handshake. Produces every stall, flush and PC-redirect control for IF, IF/ID and ID/EX. It is the only block that drives those pipeline-register controls.

## Interface
Parameters:
- `XLEN`, 32, PC width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `bpu_flush`  in  1  EX-stage mispredict or jump; wrong-path instructions are in IF and ID.
- `bpu_flush_pc`  in  XLEN  correct target for `bpu_flush`.
- `id_rs1`, `id_rs2`  in  5 each  ID-stage source register indices.
- `id_re1`, `id_re2`  in  1 each  ID instruction actually reads rs1/rs2.
- `ex_rd`  in  5  EX-stage destination register.
- `ex_we`  in  1  EX instruction writes the register file.
- `ex_is_load`  in  1  EX instruction is a load.
- `if_ready`  in  1  fetch returns a valid instruction this cycle.
- `pc_stall`  out  1  hold the PC register.
- `ifid_stall`  out  1  hold IF/ID.
- `ifid_flush`  out  1  load a bubble into IF/ID.
- `idex_flush`  out  1  load a bubble into ID/EX.
- `redirect_valid`  out  1  PC loads `redirect_pc` at the next edge.
- `redirect_pc`  out  XLEN  redirect target.

## Operation
- FSM states: `RUN` and `REDIR_WAIT`. The register `pend_pc` (XLEN) holds the redirect target while a redirect is pending.
- Load-use hazard (`lu`): `ex_is_load & ex_we & (ex_rd != 0) & ((id_re1 & id_rs1 == ex_rd) | (id_re2 & id_rs2 == ex_rd))`.
- Behaviour in `RUN`, highest priority first:
  - `bpu_flush=1`:
    - Drive `redirect_valid=1`, `redirect_pc=bpu_flush_pc`, `ifid_flush=1`, `idex_flush=1`, `pc_stall=0`.
    - If `if_ready=1`, stay in `RUN`. Otherwise capture `pend_pc<=bpu_flush_pc` and go to `REDIR_WAIT`.
    - `lu` is ignored because the ID instruction is wrong-path.
  - `lu=1`:
    - Drive `pc_stall=1`, `ifid_stall=1`, `idex_flush=1` for one bubble cycle. `if_ready` is ignored.
    - The next cycle re-evaluates; the load is now in MEM, so `lu` clears.
  - `if_ready=0`: drive `pc_stall=1` and `ifid_flush=1`; the ID/EX pipeline continues draining.
  - Otherwise all control outputs are 0.
- Behaviour in `REDIR_WAIT`:
  - Drive `redirect_valid=1`, `redirect_pc=pend_pc`, `ifid_flush=1`, `idex_flush=1`.
  - Go to `RUN` on `if_ready=1`.
  - If `bpu_flush=1` arrives here, overwrite `pend_pc` with the new target and output the new target the same cycle.
- `ifid_stall` and `ifid_flush` are never both 1. Stall wins only in the `lu` case, and flush is then 0.

## Timing
- All control outputs are combinational from state, `pend_pc` and the inputs, and are valid in the same cycle as the causing input.
- Redirect latency: the first correct-path instruction is fetched in the cycle after `bpu_flush`. The branch costs 2 bubbles; each `if_ready=0` cycle adds one more.
- Load-use costs exactly 1 bubble.
- Reset (`rst_n=0` at an edge):
  - Next state is `RUN`, and `pend_pc` is cleared to 0.
  - While `rst_n=0`, every output is forced to 0 (including `redirect_pc`) regardless of inputs.
- Reset asserted in `REDIR_WAIT` drops the pending redirect. The top-level PC reset value takes over.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds four 32-bit free-running wrapping counters, cleared by reset: `perf_cycles`, `perf_flushes` (RUN-state `bpu_flush`), `perf_lu_stalls`, `perf_fetch_wait` (cycles with `if_ready=0` in either state).
  - Each counter is an output port of width 32.
- Not defined: the counters and their ports are absent, and control behaviour is identical.

## Structure
- The shared core package/header holds:
  - FSM state encodings `PC_RUN`, `PC_REDIR_WAIT`.
  - `XLEN`.
  - Existing `NPC_*` constants, unchanged.
- One sub-module, `lu_detect`: purely combinational and computes `lu`. The FSM, `pend_pc` and the counters stay in `pipe_ctrl`.

## Test plan
- Taken branch: `bpu_flush=1`, `bpu_flush_pc=0x0000_0040`, `if_ready=1` → same cycle `redirect_valid=1`, `redirect_pc=0x40`, `ifid_flush=1`, `idex_flush=1`; next cycle all outputs 0 and state `RUN`.
- Redirect with slow fetch: `bpu_flush=1`, `bpu_flush_pc=0x100`, `if_ready=0` for 3 cycles, then `if_ready=1` → `redirect_valid=1`, `redirect_pc=0x100` on all 4 cycles; `RUN` after the 4th edge.
- Load-use: `ex_is_load=1`, `ex_we=1`, `ex_rd=5`, `id_rs2=5`, `id_re2=1` → `pc_stall=1`, `ifid_stall=1`, `idex_flush=1`, `ifid_flush=0`. Repeated with `ex_rd=0` → no stall.
- Flush vs load-use: both conditions true in the same cycle → flush outputs only, `ifid_stall=0`, `pc_stall=0`.
- Reset mid-redirect: enter `REDIR_WAIT` with `pend_pc=0x200`, then `rst_n=0` for 1 cycle → all outputs 0 during reset; after release with idle inputs, `redirect_valid=0`.
- With `PIPE_CTRL_PERF_EN`: 10 cycles containing 2 flushes (with `if_ready=1`) and 1 load-use → `perf_cycles=10`, `perf_flushes=2`, `perf_lu_stalls=1`, `perf_fetch_wait=0`.
